// File: rtl/pi1_sevseg_pkg.sv
// rtl/pi1_sevseg_pkg.sv - PI1 op encodings, register offsets and seven-segment helpers
package pi1_sevseg_pkg;

    typedef enum logic [1:0] {
        PINOOP = 2'b00,
        PIWROP = 2'b01,
        PIRDOP = 2'b10,
        PIRWOP = 2'b11
    } pi1_op_e;

    localparam logic [1:0] REG_DIGITS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_BRIGHT = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments, bit order g..a
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sevseg_hexdec.sv
// rtl/sevseg_hexdec.sv - combinational hex nibble to active-low segment decoder
module sevseg_hexdec
    import pi1_sevseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/pi1_sevseg.sv
// rtl/pi1_sevseg.sv - PI1 slave multiplexing an 8-digit common-anode display
// Optional brightness PWM enabled by defining PI1_SEVSEG_PWM_EN.
module pi1_sevseg
    import pi1_sevseg_pkg::*;
#(
    parameter int ARCHBITSZ = 32,
    parameter int CLKFREQ   = 50000000,
    parameter int REFRESHHZ = 1000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ARCHBITSZ-3:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic [ARCHBITSZ-1:0]   pi1_mapsz_o,
    output logic [7:0]             an_o,
    output logic [6:0]             seg_o,
    output logic                   dp_o
);

    localparam int PERIOD = CLKFREQ / (8 * REFRESHHZ);
    localparam int CNTW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(PERIOD - 1);

    logic [31:0]     r_digits;
    logic [15:0]     r_ctrl;
    logic            r_rdy;
    logic [31:0]     r_data;
    logic [CNTW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    pi1_op_e     w_op;
    logic [1:0]  w_reg;
    logic        w_accept;
    logic        w_wr;
    logic [31:0] w_rdval;
    logic [31:0] w_wdata;
    logic [3:0]  w_bright;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic        w_on;
    logic        w_unused_addr;

    assign w_op          = pi1_op_e'(pi1_op_i);
    assign w_reg         = pi1_addr_i[1:0];
    assign w_unused_addr = ^pi1_addr_i[ARCHBITSZ-3:2];
    assign w_accept      = r_rdy && (w_op != PINOOP);
    assign w_wr          = w_accept && ((w_op == PIWROP) || (w_op == PIRWOP));
    assign w_wdata       = byte_merge(w_rdval, pi1_data_i, pi1_sel_i);

`ifdef PI1_SEVSEG_PWM_EN
    logic [3:0] r_bright;
    logic [3:0] r_pwm;
    assign w_bright = r_bright;
`else
    assign w_bright = 4'd0;
`endif

    always_comb begin
        w_rdval = 32'd0;
        case (w_reg)
            REG_DIGITS: w_rdval = r_digits;
            REG_CTRL:   w_rdval = {16'd0, r_ctrl};
            REG_BRIGHT: w_rdval = {28'd0, w_bright};
            default:    w_rdval = 32'd0;
        endcase
    end

    // Response is captured at the accept edge and held until the next accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdy  <= 1'b1;
            r_data <= 32'd0;
        end else if (w_accept) begin
            r_rdy  <= 1'b0;
            r_data <= (w_op == PIWROP) ? 32'd0 : w_rdval;
        end else begin
            r_rdy  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_digits <= 32'd0;
            r_ctrl   <= 16'd0;
`ifdef PI1_SEVSEG_PWM_EN
            r_bright <= 4'd15;
`endif
        end else if (w_wr) begin
            case (w_reg)
                REG_DIGITS: r_digits <= w_wdata;
                REG_CTRL:   r_ctrl   <= w_wdata[15:0];
`ifdef PI1_SEVSEG_PWM_EN
                REG_BRIGHT: r_bright <= w_wdata[3:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_nib = r_digits[{r_idx, 2'b00} +: 4];

    sevseg_hexdec u_hexdec (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

`ifdef PI1_SEVSEG_PWM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_pwm <= 4'd0;
        else       r_pwm <= r_pwm + 4'd1;
    end
    assign w_on = r_ctrl[r_idx] && (r_pwm < r_bright);
`else
    assign w_on = r_ctrl[r_idx];
`endif

    // A dark slot blanks anodes, segments and decimal point together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_on ? ~(8'd1 << r_idx) : 8'hFF;
            r_seg <= w_on ? w_seg : SEG_OFF;
            r_dp  <= w_on ? ~r_ctrl[{1'b1, r_idx}] : 1'b1;
        end
    end

    assign pi1_rdy_o   = r_rdy;
    assign pi1_data_o  = r_data;
    assign pi1_mapsz_o = ARCHBITSZ'(16);
    assign an_o        = r_an;
    assign seg_o       = r_seg;
    assign dp_o        = r_dp;

endmodule

// File: tb/tb_pi1_sevseg.sv
// tb/tb_pi1_sevseg.sv - self-checking bench for pi1_sevseg against a behavioural model
module tb_pi1_sevseg;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op_i = 2'b00;
    logic [29:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_o;
    logic        rdy_o;
    logic [31:0] mapsz_o;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    logic [31:0] m_digits;
    logic [15:0] m_ctrl;
    logic [3:0]  m_bright;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    pi1_sevseg #(.ARCHBITSZ(32), .CLKFREQ(800), .REFRESHHZ(10)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pi1_op_i    (op_i),
        .pi1_addr_i  (addr_i),
        .pi1_data_i  (data_i),
        .pi1_data_o  (data_o),
        .pi1_sel_i   (sel_i),
        .pi1_rdy_o   (rdy_o),
        .pi1_mapsz_o (mapsz_o),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_digits = 32'd0;
        m_ctrl   = 16'd0;
        m_bright = 4'd15;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return m_digits;
            2'd1: return {16'd0, m_ctrl};
`ifdef PI1_SEVSEG_PWM_EN
            2'd2: return {28'd0, m_bright};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] v;
        v = m_read(a);
        for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
        case (a)
            2'd0: m_digits = v;
            2'd1: m_ctrl = v[15:0];
`ifdef PI1_SEVSEG_PWM_EN
            2'd2: m_bright = v[3:0];
`endif
            default: ;
        endcase
    endtask

    // One request from an idle bus; junk is driven while rdy is low and must be ignored
    task automatic xfer(input logic [1:0] op, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] exp;
        exp = (op == 2'b01) ? 32'd0 : m_read(a);
        chk("rdy_idle", {31'd0, rdy_o}, 32'd1);
        op_i   = op;
        addr_i = {28'($urandom), a};
        data_i = d;
        sel_i  = sel;
        @(posedge clk);
        if (op[0]) m_write(a, d, sel);
        @(negedge clk);
        chk("rdy_low", {31'd0, rdy_o}, 32'd0);
        op_i   = 2'($urandom_range(1, 3));
        addr_i = 30'($urandom);
        data_i = $urandom;
        sel_i  = 4'hF;
        @(negedge clk);
        chk("rdy_high", {31'd0, rdy_o}, 32'd1);
        chk("rdata", data_o, exp);
        op_i = 2'b00;
    endtask

    // Output seen after n edges reflects the digit slot and registers after n-1 edges
    task automatic scan(input int ncyc);
        int n, idx;
        logic on;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        repeat (ncyc) begin
            @(negedge clk);
            n = cyc;
            if (n == 0) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                idx = ((n - 1) / P) % 8;
                on = m_ctrl[idx];
`ifdef PI1_SEVSEG_PWM_EN
                on = on && (((n - 1) % 16) < int'(m_bright));
`endif
                e_an  = on ? ~(8'd1 << idx) : 8'hFF;
                e_seg = on ? seg_tab[m_digits[4*idx +: 4]] : 7'h7F;
                e_dp  = on ? ~m_ctrl[8 + idx] : 1'b1;
            end
            chk("an", {24'd0, an_o}, {24'd0, e_an});
            chk("seg", {25'd0, seg_o}, {25'd0, e_seg});
            chk("dp", {31'd0, dp_o}, {31'd0, e_dp});
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", {31'd0, rdy_o}, 32'd1);
        chk("rst_data", data_o, 32'd0);
        chk("mapsz", mapsz_o, 32'd16);
        scan(3);

        xfer(2'b01, 2'd0, 32'h89ABCDEF, 4'hF);
        xfer(2'b10, 2'd0, 32'h0, 4'hF);
        xfer(2'b01, 2'd1, 32'h00000181, 4'b0001);
        xfer(2'b10, 2'd1, 32'h0, 4'h0);
        xfer(2'b11, 2'd1, 32'h0000FFFF, 4'hF);
        xfer(2'b10, 2'd1, 32'h0, 4'h0);
        xfer(2'b01, 2'd3, 32'hDEADBEEF, 4'hF);
        xfer(2'b10, 2'd3, 32'h0, 4'h0);
        xfer(2'b01, 2'd2, 32'h00000008, 4'hF);
        xfer(2'b10, 2'd2, 32'h0, 4'h0);
        xfer(2'b01, 2'd2, 32'h0000000F, 4'hF);

        xfer(2'b01, 2'd1, 32'h000000FF, 4'hF);
        xfer(2'b01, 2'd0, 32'h76543210, 4'hF);
        scan(100);

        xfer(2'b01, 2'd1, 32'h00000202, 4'hF);
        scan(90);

`ifdef PI1_SEVSEG_PWM_EN
        xfer(2'b01, 2'd1, 32'h000000FF, 4'hF);
        xfer(2'b01, 2'd2, 32'h00000000, 4'hF);
        scan(40);
        xfer(2'b01, 2'd2, 32'h00000008, 4'hF);
        scan(40);
        xfer(2'b01, 2'd2, 32'h0000000F, 4'hF);
`endif

        for (int i = 0; i < 8; i++) begin
            xfer(2'($urandom_range(1, 3)), 2'($urandom), $urandom, 4'($urandom));
            xfer(2'b01, 2'd0, $urandom, 4'($urandom));
            xfer(2'b11, 2'd1, $urandom, 4'($urandom));
            xfer(2'b10, 2'($urandom), 32'h0, 4'h0);
            scan(30 + $urandom_range(0, 40));
        end

        xfer(2'b01, 2'd1, 32'h0000FFFF, 4'hF);
        xfer(2'b01, 2'd0, 32'h88888888, 4'hF);
        scan(17);
        op_i = 2'b01; addr_i = 30'd1; data_i = 32'h0; sel_i = 4'hF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", {24'd0, an_o}, 32'h000000FF);
        chk("arst_seg", {25'd0, seg_o}, 32'h0000007F);
        chk("arst_dp", {31'd0, dp_o}, 32'd1);
        chk("arst_rdy", {31'd0, rdy_o}, 32'd1);
        chk("arst_data", data_o, 32'd0);
        model_reset();
        op_i = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scan(15);
        xfer(2'b10, 2'd1, 32'h0, 4'h0);
        xfer(2'b01, 2'd0, $urandom, 4'hF);
        xfer(2'b01, 2'd1, 32'h0000A5FF, 4'hF);
        scan(85);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
